// File: rtl/ilv_pkg.sv
// ilv_pkg: shared constants and per-mode lookups for the OFDM bit interleaver.
// Modes select Ncbps, the column depth d and the second-permutation span s.
package ilv_pkg;

    localparam int NCBPS_MAX = 1152;
    localparam int AW        = 11;

    typedef enum logic [1:0] {
        MOD_BPSK  = 2'd0,
        MOD_QPSK  = 2'd1,
        MOD_QAM16 = 2'd2,
        MOD_QAM64 = 2'd3
    } mod_t;

    function automatic logic [AW-1:0] ncbps_of(input logic [1:0] md);
        logic [AW-1:0] r;
        unique case (md)
            MOD_BPSK:  r = AW'(192);
            MOD_QPSK:  r = AW'(384);
            MOD_QAM16: r = AW'(768);
            default:   r = AW'(1152);
        endcase
        return r;
    endfunction

    function automatic logic [AW-1:0] d_of(input logic [1:0] md);
        logic [AW-1:0] r;
        unique case (md)
            MOD_BPSK:  r = AW'(16);
            MOD_QPSK:  r = AW'(32);
            MOD_QAM16: r = AW'(64);
            default:   r = AW'(96);
        endcase
        return r;
    endfunction

    function automatic logic [1:0] s_of(input logic [1:0] md);
        logic [1:0] r;
        unique case (md)
            MOD_BPSK:  r = 2'd1;
            MOD_QPSK:  r = 2'd1;
            MOD_QAM16: r = 2'd2;
            default:   r = 2'd3;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

endpackage

// File: rtl/ilv_ram.sv
// ilv_ram: two-bank 1-bit simple dual-port RAM with synchronous read.
// Port address MSB picks the bank; banks are packed back to back.
module ilv_ram
    import ilv_pkg::*;
(
    input  logic        clk,
    input  logic        wr_en,
    input  logic [AW:0] wr_addr,
    input  logic        wr_data,
    input  logic        rd_en,
    input  logic [AW:0] rd_addr,
    output logic        rd_data
);

    logic          mem [2*NCBPS_MAX];
    logic [AW:0]   wr_phys;
    logic [AW:0]   rd_phys;

    assign wr_phys = wr_addr[AW] ? {1'b0, wr_addr[AW-1:0]} + (AW+1)'(NCBPS_MAX)
                                 : {1'b0, wr_addr[AW-1:0]};
    assign rd_phys = rd_addr[AW] ? {1'b0, rd_addr[AW-1:0]} + (AW+1)'(NCBPS_MAX)
                                 : {1'b0, rd_addr[AW-1:0]};

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_phys] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_phys];
        end
    end

endmodule

// File: rtl/interleaver.sv
// interleaver: 802.16 two-step bit interleaver over ping-pong RAM banks.
// Bits are written at their permuted address and read out in order.
module interleaver
    import ilv_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_bits,
    input  logic       in_valid,
    input  logic [1:0] mod,
    output logic       out_bits,
    output logic       out_valid,
    output logic       overrun
);

    logic [1:0]    wmod_q;
    logic [1:0]    emod;
    logic [3:0]    row;
    logic [1:0]    r3;
    logic [1:0]    c3;
    logic [1:0]    t3;
    logic [AW-1:0] col;
    logic [AW-1:0] m;
    logic [AW-1:0] j;
    logic [AW-1:0] d;
    logic [AW-1:0] n;
    logic [1:0]    s;
    logic          wb;
    logic          first;
    logic          wr_last;
    logic          hand;

    logic          rd_active;
    logic          rd_bank;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] rd_n;
    logic          rd_last;
    logic          rd_v1;
    logic          ram_q;

    assign first   = (row == 4'd0) && (col == '0);
    assign emod    = first ? mod : wmod_q;
    assign d       = d_of(emod);
    assign n       = ncbps_of(emod);
    assign s       = s_of(emod);
    assign wr_last = in_valid && (row == 4'd11) && (col == d - 1'b1);
    assign rd_last = rd_active && (rd_addr == rd_n - 1'b1);
    // A finished block is handed over unless the reader is mid-burst.
    assign hand    = wr_last && !(rd_active && !rd_last);

    // r3 tracks row mod 3, so (c3 - row) mod 3 needs no divider.
    assign t3 = (c3 >= r3) ? c3 - r3 : c3 + 2'd3 - r3;

    always_comb begin
        j = m;
        case (s)
            2'd2:    j = {m[AW-1:1], m[0] ^ row[0]};
            2'd3:    j = m - {{(AW-2){1'b0}}, c3} + {{(AW-2){1'b0}}, t3};
            default: j = m;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row     <= '0;
            col     <= '0;
            m       <= '0;
            r3      <= '0;
            c3      <= '0;
            wmod_q  <= '0;
            wb      <= 1'b0;
            overrun <= 1'b0;
        end else if (in_valid) begin
            if (first) begin
                wmod_q <= mod;
            end
            if (wr_last) begin
                row <= '0;
                col <= '0;
                m   <= '0;
                r3  <= '0;
                c3  <= '0;
                if (hand) begin
                    wb <= ~wb;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (row == 4'd11) begin
                row <= '0;
                r3  <= '0;
                col <= col + 1'b1;
                c3  <= inc3(c3);
                m   <= col + 1'b1;
            end else begin
                row <= row + 1'b1;
                r3  <= inc3(r3);
                m   <= m + d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_active <= 1'b0;
            rd_bank   <= 1'b0;
            rd_addr   <= '0;
            rd_n      <= '0;
            rd_v1     <= 1'b0;
            out_valid <= 1'b0;
            out_bits  <= 1'b0;
        end else begin
            rd_v1     <= rd_active;
            out_valid <= rd_v1;
            out_bits  <= rd_v1 & ram_q;
            if (hand) begin
                rd_active <= 1'b1;
                rd_bank   <= wb;
                rd_addr   <= '0;
                rd_n      <= n;
            end else if (rd_active) begin
                rd_active <= !rd_last;
                rd_addr   <= rd_last ? '0 : rd_addr + 1'b1;
            end
        end
    end

    ilv_ram u_ram (
        .clk     (clk),
        .wr_en   (in_valid),
        .wr_addr ({wb, j}),
        .wr_data (in_bits),
        .rd_en   (rd_active),
        .rd_addr ({rd_bank, rd_addr}),
        .rd_data (ram_q)
    );

endmodule

// File: tb/tb_interleaver.sv
// tb_interleaver: directed checks of the interleaver against the
// closed-form 802.16 permutation.
module tb_interleaver;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_bits;
    logic       in_valid;
    logic [1:0] mod;
    logic       out_bits;
    logic       out_valid;
    logic       overrun;

    int passed = 0;
    int total  = 0;

    interleaver dut (
        .clk       (clk),
        .reset     (reset),
        .in_bits   (in_bits),
        .in_valid  (in_valid),
        .mod       (mod),
        .out_bits  (out_bits),
        .out_valid (out_valid),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit tx [0:3455];
    bit cap [$];
    int runs [$];
    int cur_run   = 0;
    int last_in   = -100;
    int first_out = -1;

    always @(posedge clk) begin
        #1;
        if (in_valid) last_in = cyc;
        if (out_valid) begin
            if (first_out < 0) first_out = cyc;
            cap.push_back(out_bits);
            cur_run++;
        end else if (cur_run != 0) begin
            runs.push_back(cur_run);
            cur_run = 0;
        end
    end

    function automatic int ncbps(input int md);
        int ncpc;
        ncpc = (md == 0) ? 1 : (md == 1) ? 2 : (md == 2) ? 4 : 6;
        return 192 * ncpc;
    endfunction

    function automatic int perm(input int k, input int md);
        int n, s, mm;
        n  = ncbps(md);
        s  = (n / 192 + 1) / 2;
        mm = (n / 12) * (k % 12) + k / 12;
        return s * (mm / s) + (mm + n - (12 * mm) / n) % s;
    endfunction

    // Returns -1 when cap[off..] matches the permuted block at tx[base..].
    function automatic int first_bad(input int base, input int md, input int off);
        bit e [0:1151];
        int n;
        n = ncbps(md);
        for (int k = 0; k < n; k++) e[perm(k, md)] = tx[base + k];
        for (int i = 0; i < n; i++) begin
            if (off + i >= cap.size()) return i;
            if (cap[off + i] != e[i]) return i;
        end
        return -1;
    endfunction

    function automatic int ones_at();
        int idx;
        idx = -1;
        for (int i = 0; i < cap.size(); i++)
            if (cap[i]) idx = (idx == -1) ? i : -2;
        return idx;
    endfunction

    task automatic clear_cap();
        cap.delete();
        runs.delete();
        cur_run   = 0;
        first_out = -1;
    endtask

    task automatic fill(input int base, input int n, input int one_at);
        for (int i = 0; i < n; i++)
            tx[base + i] = (one_at < 0) ? bit'($urandom_range(0, 1)) : (i == one_at);
    endtask

    task automatic send_block(input int md, input int base);
        int n;
        n = ncbps(md);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) mod = 2'(md);
            if (k == 5) mod = 2'(md ^ 1);
            in_valid = 1'b1;
            in_bits  = tx[base + k];
        end
    endtask

    task automatic idle(input int c);
        @(negedge clk);
        in_valid = 1'b0;
        in_bits  = 1'b0;
        repeat (c) @(negedge clk);
    endtask

    task automatic wait_runs(input int cnt, input int budget, input string nm);
        int c;
        c = 0;
        while (runs.size() < cnt && c < budget) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (runs.size() < cnt)
            $display("FAIL %s_timeout: bursts=%0d required=%0d", nm, runs.size(), cnt);
        else passed++;
    endtask

    task automatic test_reset();
        total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else passed++;
        total++;
        if (out_bits !== 1'b0) $display("FAIL reset_out_bits: got %b want 0", out_bits);
        else passed++;
        total++;
        if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun);
        else passed++;
    endtask

    task automatic test_single(input int md, input int k1, input int want, input string nm);
        int idx, lat, len;
        clear_cap();
        fill(0, ncbps(md), k1);
        send_block(md, 0);
        idle(4);
        wait_runs(1, 3000, nm);
        len = (runs.size() > 0) ? runs[0] : 0;
        total++;
        if (len !== ncbps(md)) $display("FAIL %s_len: got %0d want %0d", nm, len, ncbps(md));
        else passed++;
        idx = ones_at();
        total++;
        if (idx !== want) $display("FAIL %s_one_index: got %0d want %0d", nm, idx, want);
        else passed++;
        lat = first_out - last_in;
        total++;
        if (lat !== 2) $display("FAIL %s_latency: got %0d want 2", nm, lat);
        else passed++;
    endtask

    task automatic test_walk64();
        int bad;
        clear_cap();
        fill(0, 1152, -1);
        send_block(3, 0);
        idle(4);
        wait_runs(1, 3000, "walk64");
        bad = first_bad(0, 3, 0);
        total++;
        if (bad !== -1) $display("FAIL walk64_data: first bad index %0d want none", bad);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int bad, len;
        clear_cap();
        fill(0, 1152, -1);
        send_block(1, 0);
        send_block(1, 384);
        send_block(1, 768);
        idle(4);
        wait_runs(1, 3000, "b2b");
        repeat (400) @(negedge clk);
        len = (runs.size() > 0) ? runs[0] : 0;
        total++;
        if (len !== 1152) $display("FAIL b2b_burst_len: got %0d want 1152", len);
        else passed++;
        for (int b = 0; b < 3; b++) begin
            bad = first_bad(384 * b, 1, 384 * b);
            total++;
            if (bad !== -1) $display("FAIL b2b_data%0d: first bad index %0d want none", b, bad);
            else passed++;
        end
        total++;
        if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b want 0", overrun);
        else passed++;
    endtask

    task automatic test_overrun();
        int bad, len;
        clear_cap();
        fill(0, 1152, -1);
        fill(1152, 192, -1);
        fill(1344, 192, -1);
        send_block(3, 0);
        send_block(0, 1152);
        send_block(0, 1344);
        idle(4);
        wait_runs(1, 3000, "ovr");
        repeat (300) @(negedge clk);
        total++;
        if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun);
        else passed++;
        len = (runs.size() > 0) ? runs[0] : 0;
        total++;
        if (len !== 1152) $display("FAIL ovr_burst_len: got %0d want 1152", len);
        else passed++;
        bad = first_bad(0, 3, 0);
        total++;
        if (bad !== -1) $display("FAIL ovr_data: first bad index %0d want none", bad);
        else passed++;
        total++;
        if (runs.size() !== 1) $display("FAIL ovr_dropped: bursts %0d want 1", runs.size());
        else passed++;
    endtask

    task automatic test_reset_mid();
        int c, bad, len;
        clear_cap();
        fill(0, 1152, -1);
        send_block(3, 0);
        idle(1);
        c = 0;
        while (cap.size() < 100 && c < 2000) begin
            @(negedge clk);
            c++;
        end
        reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b want 0", out_valid);
        else passed++;
        total++;
        if (overrun !== 1'b0) $display("FAIL mid_reset_overrun: got %b want 0", overrun);
        else passed++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        clear_cap();
        fill(0, 384, -1);
        send_block(1, 0);
        idle(4);
        wait_runs(1, 2000, "mid");
        len = (runs.size() > 0) ? runs[0] : 0;
        total++;
        if (len !== 384) $display("FAIL mid_len: got %0d want 384", len);
        else passed++;
        bad = first_bad(0, 1, 0);
        total++;
        if (bad !== -1) $display("FAIL mid_data: first bad index %0d want none", bad);
        else passed++;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_bits  = 1'b0;
        mod      = 2'd0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        test_single(0, 1, 16, "bpsk");
        test_single(2, 13, 64, "qam16");
        test_single(3, 25, 97, "qam64");
        test_walk64();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
